sysbus_uart_tx: RTL
===================

// Module: sysbus_uart_tx
// PURPOSE
//  Memory-mapped serial output peripheral on the CPU's shared sysbus. The CPU
//  stores bytes to DATA_ADDR; they queue in a small FIFO and are shifted out on
//  txd as 8N1-style frames. A load from STAT_ADDR returns FIFO/transmitter status.
// PARAMETERS
//  WORD_W     8     sysbus data width; also frame data bit count
//  OP_W       3     opcode width; address width AW = WORD_W-OP_W
//  DEPTH      4     FIFO entries (power of 2, >=2)
//  BAUD_DIV   16    clock cycles per serial bit (>=2)
//  DATA_ADDR  5'h1E write-only data register address
//  STAT_ADDR  5'h1F read-only status register address
// PORTS
//  clock   in     1       system clock, rising edge active
//  reset   in     1       synchronous, active-high reset
//  sysbus  inout  WORD_W  shared tri-state data bus
//  addr    in     AW      address from CPU MAR
//  cs      in     1       bus cycle strobe from CPU sequencer
//  r_nw    in     1       1 = CPU read (load), 0 = CPU write (store)
//  txd     out    1       serial output, idle high
//  busy    out    1       1 while FIFO non-empty or frame in progress
// BEHAVIOUR
//  Reset (sync, high): FIFO empty, ovf=0, FSM IDLE, txd=1, busy=0, sysbus 'z;
//   asserted mid-frame aborts frame, txd=1 from next edge.
//  Write: cs&!r_nw&addr==DATA_ADDR sampled at edge -> sysbus pushed to FIFO.
//   FIFO full and no pop same edge -> byte dropped, ovf set (sticky).
//   Full with pop same edge -> push accepted (pop before push).
//  Read: cs&r_nw&addr==STAT_ADDR -> sysbus driven combinationally with
//   {0.., ovf, busy, full, empty} (bit3..bit0); else sysbus='z always.
//   ovf cleared at the edge ending that read cycle (set wins if same edge).
//  Other addresses: no drive, no state change.
//  FIFO: wr/rd pointers with one extra wrap bit; full = ptrs equal except MSB.
//  FSM, each non-IDLE bit held BAUD_DIV cycles by down-counter:
//   IDLE : txd=1; FIFO non-empty -> pop into shift reg, -> START
//   START: txd=0; -> DATA, bit index 0
//   DATA : txd=shift[0], LSB first; after WORD_W bits -> STOP
//   STOP : txd=1; end: FIFO non-empty -> pop, -> START (no idle gap), else IDLE
//  Latency: store accepted at edge N with FSM IDLE -> txd=0 from edge N+1.
//  Frame length exactly (WORD_W+2)*BAUD_DIV cycles.
//  busy = !empty | (state!=IDLE), registered-consistent with FIFO/FSM state.
//  txd registered (glitch-free); sysbus drive is the only combinational output.
// TESTING
//  1 Reset 3 cycles -> txd=1, busy=0, STAT read = 8'h01, sysbus 'z otherwise.
//  2 Store 8'hA5 -> txd low at next edge, bits 1,0,1,0,0,1,0,1 each 16 cycles,
//    stop high; total 160 cycles; then STAT = 8'h01.
//  3 Store 8'h01,8'h02 back-to-back -> two frames, no idle cycle between, 320 cycles.
//  4 Store 6 bytes while first frame runs -> 6th dropped (5 fit: 1 shifting + 4),
//    STAT = 8'h0E; read again -> ovf cleared, 8'h06.
//  5 Assert reset at cycle 70 of a frame -> txd=1 next edge, FIFO empty, STAT 8'h01.
//  6 cs with addr 5'h00 read/write -> sysbus not driven by block, FIFO unchanged.

Source files
------------

// File: rtl/sysbus_uart_tx.sv
`timescale 1ns/1ps
// Store-to-serial peripheral on the shared sysbus: bytes written to DATA_ADDR queue
// in a small FIFO and leave on txd as start/data/stop frames; STAT_ADDR reads status.
module sysbus_uart_tx #(
    parameter int WORD_W   = 8,
    parameter int OP_W     = 3,
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 16,
    parameter logic [WORD_W-OP_W-1:0] DATA_ADDR = 5'h1E,
    parameter logic [WORD_W-OP_W-1:0] STAT_ADDR = 5'h1F
) (
    input  logic                     clock,
    input  logic                     reset,
    inout  wire  [WORD_W-1:0]        sysbus,
    input  logic [WORD_W-OP_W-1:0]   addr,
    input  logic                     cs,
    input  logic                     r_nw,
    output logic                     txd,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [WORD_W-1:0] shift;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              ovf;
    logic [WORD_W-1:0] mem [DEPTH];

    logic wr_hit;
    logic stat_rd;
    logic empty;
    logic full;
    logic bit_end;
    logic pop;
    logic push;
    logic [WORD_W-1:0] head;
    logic [WORD_W-1:0] stat_word;

    assign wr_hit  = cs && !r_nw && (addr == DATA_ADDR);
    assign stat_rd = cs &&  r_nw && (addr == STAT_ADDR);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign bit_end = (cnt == '0);
    // The transmitter takes a byte when idle, or at the last cycle of a stop bit
    // so that queued frames follow each other with no idle gap.
    assign pop     = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign push    = wr_hit && (!full || pop);
    assign head    = mem[rd_ptr[PW-2:0]];
    assign busy    = !empty || (state != S_IDLE);

    assign stat_word = {{(WORD_W-4){1'b0}}, ovf, busy, full, empty};
    assign sysbus    = stat_rd ? stat_word : {WORD_W{1'bz}};

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[PW-2:0]] <= sysbus;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A dropped store in the same cycle as a status read keeps ovf set.
            if (wr_hit && full && !pop) begin
                ovf <= 1'b1;
            end else if (stat_rd) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift <= head;
                        cnt   <= BAUD_LAST;
                        state <= S_START;
                        txd   <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt     <= BAUD_LAST;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        txd     <= shift[0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt <= BAUD_LAST;
                        if (bit_idx == BIT_LAST) begin
                            state <= S_STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift <= head;
                            cnt   <= BAUD_LAST;
                            state <= S_START;
                            txd   <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            txd   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
